// File: rtl/rw_mlp_feature_loader.sv
// rw_mlp_feature_loader
// ---------------------------------------------------------------------------
// Front/back end for the combinational RedWine MLP regressor core.
//
// Incoming feature beats are packed into the 44-bit core input vector,
// feature k at bits [FEAT_W*k +: FEAT_W]. Once a frame is complete the vector
// is frozen for SETTLE_CYCLES so the core output can settle. The output is
// then captured and offered on a result port.
//
// Handshake rule, used on both stream ports: a transfer happens on a rising
// clk edge where valid and ready are both 1. A producer that raises valid
// keeps valid and its data stable until that transfer. ready may depend on
// state only, never combinationally on valid.
//
// Build option:
//   RW_LOADER_FRAME_CHECK_EN  define to check s_last framing and drive err.
//                             Leave undefined to ignore s_last. A frame is
//                             then exactly N_FEAT beats and err stays 0.
//
// Ports:
//   clk, rst   single clock; asynchronous active-high reset
//   s_valid    feature beat valid
//   s_ready    loader accepts a beat (LOAD state only)
//   s_data     unsigned FEAT_W-bit feature value
//   s_last     final feature of a frame
//   clf_inp    packed N_FEAT*FEAT_W vector driven into the core
//   clf_out    core regression output (combinational from clf_inp)
//   m_valid    result valid (HOLD state)
//   m_ready    downstream accepts the result
//   m_data     registered copy of clf_out
//   err        one-cycle framing-error pulse
// ---------------------------------------------------------------------------
module rw_mlp_feature_loader #(
  parameter int N_FEAT        = 11,
  parameter int FEAT_W        = 4,
  parameter int OUT_W         = 20,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [FEAT_W-1:0]        s_data,
  input  logic                     s_last,
  output logic [N_FEAT*FEAT_W-1:0] clf_inp,
  input  logic [OUT_W-1:0]         clf_out,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [OUT_W-1:0]         m_data,
  output logic                     err
);

  localparam int IDX_W = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
  localparam int CNT_W = 4;  // holds SETTLE_CYCLES up to 15

  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N_FEAT - 1);
  localparam logic [CNT_W-1:0] SETTLE_VAL = CNT_W'(SETTLE_CYCLES);

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] settle_cnt;
  // Goes high on the first edge after reset release. s_ready therefore
  // rises one cycle after deassertion and not during reset.
  logic             started;

  logic beat;
  logic last_slot;
  logic wr_en;
  logic frame_done;
  logic frame_err;

  assign s_ready   = started && (state == ST_LOAD);
  assign m_valid   = (state == ST_HOLD);
  assign beat      = s_valid && s_ready;
  assign last_slot = (idx == LAST_IDX);

  // Beat classification: write the slot, close the frame, or flag a framing error.
  always_comb begin
    wr_en      = 1'b0;
    frame_done = 1'b0;
    frame_err  = 1'b0;
    if (beat) begin
`ifdef RW_LOADER_FRAME_CHECK_EN
      if (s_last && !last_slot) begin
        // Early end of frame: drop this beat and restart at slot 0.
        frame_err = 1'b1;
      end else begin
        wr_en = 1'b1;
        if (last_slot) begin
          // The final slot is written either way. A missing s_last discards the frame.
          frame_done = s_last;
          frame_err  = !s_last;
        end
      end
`else
      wr_en      = 1'b1;
      frame_done = last_slot;
`endif
    end
  end

`ifndef RW_LOADER_FRAME_CHECK_EN
  // s_last carries no meaning when frames are delimited by count alone.
  logic unused_last;
  assign unused_last = s_last;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_LOAD;
      idx        <= '0;
      settle_cnt <= '0;
      started    <= 1'b0;
      clf_inp    <= '0;
      m_data     <= '0;
      err        <= 1'b0;
    end else begin
      started <= 1'b1;
      err     <= frame_err;

      if (wr_en) begin
        for (int k = 0; k < N_FEAT; k++) begin
          if (idx == IDX_W'(k)) begin
            clf_inp[k*FEAT_W +: FEAT_W] <= s_data;
          end
        end
      end

      if (frame_done || frame_err) begin
        idx <= '0;
      end else if (wr_en) begin
        idx <= idx + 1'b1;
      end

      case (state)
        ST_LOAD: begin
          if (frame_done) begin
            state      <= ST_SETTLE;
            settle_cnt <= SETTLE_VAL;
          end
        end
        ST_SETTLE: begin
          // clf_inp is frozen here. Sample the core on the cycle where the count reads 1.
          if (settle_cnt == CNT_W'(1)) begin
            m_data     <= clf_out;
            settle_cnt <= '0;
            state      <= ST_HOLD;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
        ST_HOLD: begin
          if (m_ready) begin
            state <= ST_LOAD;
          end
        end
        default: begin
          state <= ST_LOAD;
        end
      endcase
    end
  end

endmodule
